// File: rtl/coeff_unpack_pkg.sv
// Shared constants, FSM state type and word byte-swap helper for the coefficient unpacker.
// Byte swapping of incoming words is enabled by defining COEFF_UNPACK_BYTE_SWAP_EN.
package coeff_unpack_pkg;

  localparam int WORD_W  = 64;
  localparam int COEFF_W = 13;
  localparam int NCOEFF  = 256;
  localparam int BUF_W   = 80;
  localparam int NWORDS  = NCOEFF * COEFF_W / WORD_W;

  localparam int FILL_W = $clog2(BUF_W + 1);
  localparam int WCNT_W = $clog2(NWORDS + 1);
  localparam int CCNT_W = $clog2(NCOEFF + 1);
  localparam int IDX_W  = $clog2(NCOEFF);

  // A word may only be inserted if it still fits above the bits left after this cycle's pop.
  localparam logic [FILL_W-1:0] PUSH_LIMIT = FILL_W'(BUF_W - WORD_W - COEFF_W + 13);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [WORD_W-1:0] byte_swap(input logic [WORD_W-1:0] w);
    logic [WORD_W-1:0] r;
    r = '0;
    for (int i = 0; i < WORD_W / 8; i++) begin
      r[8*i +: 8] = w[WORD_W-8-8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/coeff_unpack_buffer_shift_buf.sv
// Shift buffer datapath: pops one coefficient off the bottom and appends whole words
// at the current fill level, in the same cycle if both are requested.
module unpack_shift_buf
  import coeff_unpack_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                pop,
  input  logic                push,
  input  logic [WORD_W-1:0]   word,
  output logic [COEFF_W-1:0]  head,
  output logic [FILL_W-1:0]   fill,
  output logic [FILL_W-1:0]   fill_after_pop
);

  logic [BUF_W-1:0]  buf_reg;
  logic [BUF_W-1:0]  buf_next;
  logic [BUF_W-1:0]  buf_shifted;
  logic [FILL_W-1:0] fill_reg;
  logic [FILL_W-1:0] fill_next;

  // Bits at and above fill are kept at zero (shifts bring in zeros, clear zeroes all),
  // so a plain OR is enough to merge the new word in.
  always_comb begin
    fill_after_pop = pop ? (fill_reg - FILL_W'(COEFF_W)) : fill_reg;
    buf_shifted    = pop ? (buf_reg >> COEFF_W) : buf_reg;
    buf_next       = buf_shifted;
    fill_next      = fill_after_pop;
    if (push) begin
      buf_next  = buf_shifted | (BUF_W'(word) << fill_after_pop);
      fill_next = fill_after_pop + FILL_W'(WORD_W);
    end
    if (clear) begin
      buf_next  = '0;
      fill_next = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_reg  <= '0;
      fill_reg <= '0;
    end else begin
      buf_reg  <= buf_next;
      fill_reg <= fill_next;
    end
  end

  assign head = buf_reg[COEFF_W-1:0];
  assign fill = fill_reg;

endmodule

// File: rtl/coeff_unpack_buffer.sv
// Streaming unpacker of densely packed 13-bit coefficients from 64-bit words.
// Define COEFF_UNPACK_BYTE_SWAP_EN to byte-reverse each word (big-endian memory image).
module coeff_unpack_buffer
  import coeff_unpack_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WORD_W-1:0]  word_in,
  input  logic               word_valid,
  output logic               word_ready,
  output logic [COEFF_W-1:0] coeff_out,
  output logic               coeff_valid,
  input  logic               coeff_ready,
  output logic [IDX_W-1:0]   coeff_idx,
  output logic               busy,
  output logic               done
);

  state_t             state_reg;
  state_t             state_next;
  logic [WCNT_W-1:0]  word_cnt_reg;
  logic [WCNT_W-1:0]  word_cnt_next;
  logic [CCNT_W-1:0]  coeff_cnt_reg;
  logic [CCNT_W-1:0]  coeff_cnt_next;

  logic               pop;
  logic               push;
  logic               last_pop;
  logic               clear;
  logic [FILL_W-1:0]  fill;
  logic [FILL_W-1:0]  fill_after_pop;
  logic [WORD_W-1:0]  word_ins;

`ifdef COEFF_UNPACK_BYTE_SWAP_EN
  assign word_ins = byte_swap(word_in);
`else
  assign word_ins = word_in;
`endif

  assign coeff_valid = (state_reg == RUN) && (fill >= FILL_W'(COEFF_W))
                       && (coeff_cnt_reg < CCNT_W'(NCOEFF));
  assign pop         = coeff_valid && coeff_ready;
  assign word_ready  = (state_reg == RUN) && (word_cnt_reg < WCNT_W'(NWORDS))
                       && (fill_after_pop <= PUSH_LIMIT);
  assign push        = word_valid && word_ready;
  assign last_pop    = pop && (coeff_cnt_reg == CCNT_W'(NCOEFF - 1));

  // Leftover bits are dropped on the way into DONE; the start clear covers the next run.
  assign clear = ((state_reg == IDLE) && start) || last_pop;

  unpack_shift_buf u_shift_buf (
    .clk            (clk),
    .rst            (rst),
    .clear          (clear),
    .pop            (pop),
    .push           (push),
    .word           (word_ins),
    .head           (coeff_out),
    .fill           (fill),
    .fill_after_pop (fill_after_pop)
  );

  always_comb begin
    state_next     = state_reg;
    word_cnt_next  = word_cnt_reg;
    coeff_cnt_next = coeff_cnt_reg;
    unique case (state_reg)
      IDLE: begin
        if (start) begin
          state_next     = RUN;
          word_cnt_next  = '0;
          coeff_cnt_next = '0;
        end
      end
      RUN: begin
        if (push) word_cnt_next = word_cnt_reg + 1'b1;
        if (pop) coeff_cnt_next = coeff_cnt_reg + 1'b1;
        if (last_pop) state_next = DONE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      word_cnt_reg  <= '0;
      coeff_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      word_cnt_reg  <= word_cnt_next;
      coeff_cnt_reg <= coeff_cnt_next;
    end
  end

  assign coeff_idx = coeff_cnt_reg[IDX_W-1:0];
  assign busy      = (state_reg != IDLE);
  assign done      = (state_reg == DONE);

endmodule

// File: doc/coeff_unpack_buffer.md
# coeff_unpack_buffer

Streaming unpacker that sits directly upstream of the coefficient selection mux in the lightweight Saber multiplier. It accepts 64-bit memory words holding densely packed 13-bit polynomial coefficients, LSB-first, and keeps them in a shift buffer. It presents one aligned 13-bit coefficient per cycle on a valid/ready handshake. One `start` pulse unpacks a full polynomial (256 coefficients = 52 words), then pulses `done`.

## Interface
- `WORD_W`, 64, width of incoming memory word
- `COEFF_W`, 13, coefficient width
- `NCOEFF`, 256, coefficients per polynomial; `NCOEFF*COEFF_W` must be a multiple of `WORD_W`
- `BUF_W`, 80, shift-buffer width; must be at least `WORD_W+COEFF_W+3`
- `clk` in 1: single clock, rising edge
- `rst` in 1: asynchronous, active-low reset
- `start` in 1: pulse; begins one polynomial when idle
- `word_in` in 64: packed data word
- `word_valid` in 1: `word_in` is valid
- `word_ready` out 1: block accepts `word_in` this cycle
- `coeff_out` out 13: current coefficient, equal to `buf[12:0]`
- `coeff_valid` out 1: `coeff_out` is valid
- `coeff_ready` in 1: consumer takes `coeff_out` this cycle
- `coeff_idx` out 8: index of the coefficient currently presented
- `busy` out 1: high from the cycle after an accepted `start` until `done`
- `done` out 1: one-cycle pulse after the last coefficient handshake

## Operation
- FSM states:
  - IDLE: on `start`, clear `buf`, `fill`, `word_cnt`, `coeff_cnt`; go to RUN.
  - RUN: when the final pop occurs, go to DONE.
  - DONE: assert `done` for one cycle; return to IDLE.
- A `start` pulse in RUN or DONE is ignored.
- Pop: occurs when `coeff_valid && coeff_ready`.
  - `buf` shifts right by 13.
  - `fill` decreases by 13.
  - `coeff_cnt` increments.
- Push: occurs when `word_valid && word_ready`.
  - `word_in` is inserted at bit position `fill_after_pop`.
  - `fill` increases by 64.
  - `word_cnt` increments.
- `word_ready = (state==RUN) && (word_cnt < NCOEFF*COEFF_W/WORD_W) && (fill_after_pop <= BUF_W-WORD_W-COEFF_W+13)`. With the default `BUF_W` this is `fill_after_pop <= 16`.
- `fill_after_pop` is `fill-13` when a pop occurs this cycle, otherwise `fill`.
- `coeff_valid = (state==RUN) && (fill >= 13) && (coeff_cnt < NCOEFF)`.
- Simultaneous pop and push in one cycle is legal: `fill' = fill - 13 + 64`.
- `buf` bits at and above `fill` are don't-care. `coeff_out` is only meaningful while `coeff_valid` is high.
- `fill` is never above 80 and never below 0.
- End of polynomial: with the default parameters, `fill` is 0 after the last pop. Otherwise, leftover bits are discarded on entering DONE.

## Timing
- Reset values:
  - all outputs 0 (`word_ready`, `coeff_valid`, `busy`, `done`, `coeff_out`, `coeff_idx`)
  - state IDLE, `fill` 0
- Reset asserted mid-RUN aborts the polynomial immediately. The FSM resumes only on the next `start`.
- `start` in cycle t: `word_ready` can be high in cycle t+1.
- First word accepted in cycle t: `coeff_valid` is high in cycle t+1.
- Throughput: with `word_valid` and `coeff_ready` held high, one coefficient per cycle, with no bubbles after the first coefficient.
- `coeff_out` and `coeff_idx` stay stable while `coeff_valid && !coeff_ready`.
- Last pop in cycle t: `done` is high in cycle t+1, `busy` is low in cycle t+2.

## Configuration
- Macro: `COEFF_UNPACK_BYTE_SWAP_EN`.
- Defined: each incoming word is byte-reversed before insertion (big-endian memory image).
- Undefined: `word_in` is inserted as-is.

## Structure
- Shared package holds:
  - `WORD_W`, `COEFF_W`, `NCOEFF` and the derived `NWORDS = 52`
  - FSM state enum (IDLE/RUN/DONE)
  - the byte-swap function
- One sub-module is natural: `unpack_shift_buf`, holding `buf` and `fill` and doing the pop/push datapath. The parent keeps the FSM, counters and handshake logic.

## Test plan
- Reset: drive `rst=0` mid-RUN after 10 coefficients → all outputs 0 next cycle; `start` afterwards restarts with `coeff_idx=0`.
- Full polynomial: pack coefficient i = i for i = 0..255 into 52 words; hold both valid and ready high → 256 in-order values, one per cycle, `done` pulses exactly once.
- Word boundary: word0=`0x0000_0000_0000_1FFF`, word1=`0x1` → coefficients `0x1FFF, 0, 0, 0, 0x1000`.
- Back-pressure: `coeff_ready` low for 20 cycles after the first word → `word_ready` stays 0 and `coeff_out=0x1FFF` stays stable; on release the stream resumes with no loss.
- Starved input: `word_valid` toggles every 3 cycles → `coeff_valid` drops only when `fill < 13`; values stay in order; `start` pulsed during RUN is ignored.
- Macro defined: word0=`0x0102_0304_0506_0708` → first coefficient is `0x0201`, i.e. `buf[12:0]` after the byte swap (`0x0807_0605_0403_0201`).
